// File: rtl/multiport_register_file.sv
// rtl/multiport_register_file.sv - one write port, N registered read ports, write-first bypass, clear sequencer (optional MPRF_BYTE_WRITE_EN)
module multiport_register_file #(
    parameter int word_width = 32,
    parameter int length     = 128,
    parameter int READ_PORTS = 2,
    localparam int AW        = (length > 1) ? $clog2(length) : 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             write,
    input  logic [AW-1:0]                    write_addres,
    input  logic [word_width-1:0]            in_data,
`ifdef MPRF_BYTE_WRITE_EN
    input  logic [word_width/8-1:0]          byte_en,
`endif
    input  logic [READ_PORTS-1:0]            read,
    input  logic [READ_PORTS*AW-1:0]         read_addres,
    output logic [READ_PORTS*word_width-1:0] out_data,
    output logic [READ_PORTS-1:0]            out_valid,
    input  logic                             clear_req,
    output logic                             busy
);

    localparam logic [AW:0]   LEN  = (AW+1)'(length);
    localparam logic [AW-1:0] LAST = AW'(length - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state;
    logic [AW-1:0]           ptr;
    logic [word_width-1:0]   mem [length];

    logic                    wr_en;
    logic [word_width-1:0]   wr_word;
    logic [AW-1:0]           rd_addr [READ_PORTS];
    logic [word_width-1:0]   rd_word [READ_PORTS];

    // Write is accepted only outside the sweep and for an existing entry
    assign wr_en = write && !busy && ({1'b0, write_addres} < LEN);

`ifdef MPRF_BYTE_WRITE_EN
    logic [word_width-1:0] old_word;
    assign old_word = ({1'b0, write_addres} < LEN) ? mem[write_addres] : '0;
`endif

    // Word that the write port will store: full word, or byte-merged with the old entry
    always_comb begin
        wr_word = in_data;
`ifdef MPRF_BYTE_WRITE_EN
        for (int b = 0; b < word_width/8; b++) begin
            if (!byte_en[b]) begin
                wr_word[b*8 +: 8] = old_word[b*8 +: 8];
            end
        end
`endif
    end

    // Per-port read value: out-of-range reads as 0, same-address write wins (write-first)
    always_comb begin
        for (int i = 0; i < READ_PORTS; i++) begin
            rd_addr[i] = read_addres[i*AW +: AW];
            rd_word[i] = '0;
            if ({1'b0, rd_addr[i]} < LEN) begin
                if (wr_en && (rd_addr[i] == write_addres)) begin
                    rd_word[i] = wr_word;
                end else begin
                    rd_word[i] = mem[rd_addr[i]];
                end
            end
        end
    end

    // Clear sequencer and storage update; busy is registered with the state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            ptr   <= '0;
            for (int k = 0; k < length; k++) begin
                mem[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        mem[write_addres] <= wr_word;
                    end
                    if (clear_req) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                        ptr   <= '0;
                    end
                end
                CLEAR: begin
                    mem[ptr] <= '0;
                    if (ptr == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + AW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Registered read ports; data holds when a port is idle or the sweep is running
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_valid <= '0;
        end else begin
            for (int i = 0; i < READ_PORTS; i++) begin
                if (read[i] && !busy) begin
                    out_valid[i]                         <= 1'b1;
                    out_data[i*word_width +: word_width] <= rd_word[i];
                end else begin
                    out_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule
